// File: rtl/bus_ack_responder.sv
// Purpose: far-end responder for the bus_req/bus_ack pulse handshake; in-order queue of request payloads.
// Latency: ack LATENCY cycles after the request cycle, plus any slip from the one-idle-cycle pulse gap.
// Backpressure: none upstream; requests arriving with the queue full are dropped and flag overflow.
// Optional checking: define BUS_ACK_RESPONDER_CHECK_EN to enable proto_err detection.
module bus_ack_responder #(
  parameter int DW      = 32,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       bus_req,
  input  logic [DW-1:0]              bus_data,
  output logic                       bus_ack,
  output logic [DW-1:0]              ack_data,
  output logic [$clog2(DEPTH+1)-1:0] pending,
  output logic                       overflow,
  output logic                       proto_err
);

  localparam int PW = $clog2(DEPTH+1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int GW = $clog2(LATENCY+1);

  // Queue storage. Stored age counts cycles since the request cycle, so an
  // entry written at the end of its request cycle starts at 1.
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];
  logic [GW-1:0] age_q  [DEPTH];
  logic [GW-1:0] age_d  [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          ack_q, ack_d;
  logic [DW-1:0] ack_dat_q, ack_dat_d;
  logic          ovf_q, ovf_d;

  logic req_acc;
  logic q_empty;
  logic head_elig;
  logic pop_head;
  logic pop_byp;
  logic push;
  logic drop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

`ifdef BUS_ACK_RESPONDER_CHECK_EN
  logic req_prev_q;
  logic err_q, err_d;
`endif

  // Decide this cycle's pop, push and drop. With LATENCY=1 an incoming request
  // arriving at an empty queue is already eligible and bypasses storage.
  always_comb begin
    req_acc = bus_req;
`ifdef BUS_ACK_RESPONDER_CHECK_EN
    req_acc = bus_req & ~req_prev_q;
`endif
    q_empty   = (cnt_q == '0);
    head_elig = !q_empty && ((int'(age_q[rd_ptr_q]) + 1) >= LATENCY);
    pop_head  = head_elig && !ack_q;
    pop_byp   = q_empty && req_acc && (LATENCY == 1) && !ack_q;
    push      = req_acc && !pop_byp && ((cnt_q != PW'(DEPTH)) || pop_head);
    drop      = req_acc && !pop_byp && !push;
  end

  // Next-state for queue contents, pointers, occupancy and registered outputs.
  always_comb begin
    data_d   = data_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      age_d[i] = (age_q[i] == GW'(LATENCY)) ? age_q[i] : age_q[i] + 1'b1;
    end
    if (pop_head) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push) begin
      data_d[wr_ptr_q] = bus_data;
      age_d[wr_ptr_q]  = GW'(1);
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    cnt_d     = cnt_q + PW'(push) - PW'(pop_head);
    ack_d     = pop_head | pop_byp;
    ack_dat_d = '0;
    if (pop_head) begin
      ack_dat_d = data_q[rd_ptr_q];
    end else if (pop_byp) begin
      ack_dat_d = bus_data;
    end
    ovf_d = ovf_q | drop;
  end

  // State registers; reset discards every outstanding entry at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        age_q[i]  <= '0;
      end
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      ack_q     <= 1'b0;
      ack_dat_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      data_q    <= data_d;
      age_q     <= age_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      ack_dat_q <= ack_dat_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef BUS_ACK_RESPONDER_CHECK_EN
  // Flag back-to-back request cycles, and any ack issued with nothing accepted behind it.
  always_comb begin
    err_d = err_q | (bus_req & req_prev_q) | (ack_d & q_empty & ~pop_byp);
  end

  // Sticky error flag and previous-request history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_prev_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      req_prev_q <= bus_req;
      err_q      <= err_d;
    end
  end

  assign proto_err = err_q;
`else
  assign proto_err = 1'b0;
`endif

  assign bus_ack  = ack_q;
  assign ack_data = ack_dat_q;
  assign pending  = cnt_q;
  assign overflow = ovf_q;

endmodule
